dflow_gen_sequencer: RTL

DFLOW_GEN_SEQUENCER -- requirements
Module: dflow_gen_sequencer

---
 rtl/dflow_gen_sequencer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/dflow_gen_sequencer.sv
// Store-then-replay sequencer for a QDR data-flow core: calibrate, reset, store once, replay N passes.
// Optional watchdog on CAL/STORE/REPLAY is compiled in with DFLOW_SEQ_TIMEOUT_EN.
module dflow_gen_sequencer #(
    parameter int unsigned QDR_ADDR_WIDTH = 19,
    parameter int unsigned LOOP_WIDTH     = 16,
    parameter int unsigned RST_CYCLES     = 8,
    parameter int unsigned TIMEOUT_WIDTH  = 24
) (
    input  logic                      qdr_clk,
    input  logic                      resetn,
    input  logic                      cmd_go,
    input  logic                      cmd_abort,
    input  logic [QDR_ADDR_WIDTH-1:0] cfg_addr_low,
    input  logic [QDR_ADDR_WIDTH-1:0] cfg_addr_high,
    input  logic [LOOP_WIDTH-1:0]     cfg_loops,
    input  logic [TIMEOUT_WIDTH-1:0]  cfg_timeout,
    input  logic                      init_calib_complete,
    input  logic                      compelete_store,
    input  logic                      compelete_replay,
    output logic                      sw_rst,
    output logic                      start_store,
    output logic                      start_replay,
    output logic [QDR_ADDR_WIDTH-1:0] mem_addr_low,
    output logic [QDR_ADDR_WIDTH-1:0] mem_addr_high,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [1:0]                err_code,
    output logic [LOOP_WIDTH-1:0]     loop_cnt,
    output logic [2:0]                state
);
    localparam int unsigned      CNT_W    = $clog2(RST_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CAL    = 3'd1,
        S_RST    = 3'd2,
        S_STORE  = 3'd3,
        S_REPLAY = 3'd4,
        S_GAP    = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      armed_q, armed_d;
    logic [LOOP_WIDTH-1:0]     loops_q, loops_d;
    logic [LOOP_WIDTH-1:0]     loop_cnt_d, loop_inc;
    logic [QDR_ADDR_WIDTH-1:0] addr_low_d, addr_high_d;
    logic                      done_d, error_d;
    logic [1:0]                err_code_d;

`ifdef DFLOW_SEQ_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0]  wd_q, wd_d, to_q, to_d;
`else
    logic                      unused_timeout;
    assign unused_timeout = ^cfg_timeout;
`endif

    assign state = state_q;

    // Next-state and next-value logic for every register
    always_comb begin
        state_d     = state_q;
        cnt_d       = ((state_q == S_RST) || (state_q == S_ERR)) ? cnt_q + 1'b1 : cnt_q;
        armed_d     = armed_q;
        loops_d     = loops_q;
        loop_cnt_d  = loop_cnt;
        loop_inc    = (loop_cnt == '1) ? loop_cnt : loop_cnt + 1'b1;
        addr_low_d  = mem_addr_low;
        addr_high_d = mem_addr_high;
        done_d      = done;
        error_d     = error;
        err_code_d  = err_code;
`ifdef DFLOW_SEQ_TIMEOUT_EN
        wd_d        = wd_q + 1'b1;
        to_d        = to_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_go) begin
                    addr_low_d  = cfg_addr_low;
                    addr_high_d = cfg_addr_high;
                    loops_d     = cfg_loops;
`ifdef DFLOW_SEQ_TIMEOUT_EN
                    to_d        = cfg_timeout;
`endif
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    err_code_d  = 2'd0;
                    loop_cnt_d  = '0;
                    if ((cfg_addr_low > cfg_addr_high) || (cfg_loops == '0)) begin
                        state_d    = S_ERR;
                        err_code_d = 2'd1;
                    end else begin
                        state_d = S_CAL;
                    end
                end
            end
            S_CAL: begin
                if (cmd_abort) begin
                    state_d    = S_ERR;
                    err_code_d = 2'd3;
                end else if (init_calib_complete) begin
                    state_d = S_RST;
                end
            end
            S_RST: begin
                if (cmd_abort) begin
                    state_d    = S_ERR;
                    err_code_d = 2'd3;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                if (cmd_abort) begin
                    state_d    = S_ERR;
                    err_code_d = 2'd3;
                end else if (compelete_store && armed_q) begin
                    state_d = S_GAP;
                end else if (!compelete_store) begin
                    armed_d = 1'b1;
                end
            end
            S_GAP: begin
                if (cmd_abort) begin
                    state_d    = S_ERR;
                    err_code_d = 2'd3;
                end else begin
                    state_d = S_REPLAY;
                end
            end
            S_REPLAY: begin
                if (cmd_abort) begin
                    state_d    = S_ERR;
                    err_code_d = 2'd3;
                end else if (compelete_replay && armed_q) begin
                    loop_cnt_d = loop_inc;
                    state_d    = (loop_inc < loops_q) ? S_GAP : S_DONE;
                end else if (!compelete_replay) begin
                    armed_d = 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            S_ERR: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef DFLOW_SEQ_TIMEOUT_EN
        // Watchdog only fires when nothing else moved the FSM this cycle
        if ((state_d == state_q) && (to_q != '0) && (wd_q == to_q - 1'b1) &&
            ((state_q == S_CAL) || (state_q == S_STORE) || (state_q == S_REPLAY))) begin
            state_d    = S_ERR;
            err_code_d = 2'd2;
        end
        if (state_d != state_q) begin
            wd_d = '0;
        end
`endif

        // A completion level already high at entry must go low before it counts
        if (state_d != state_q) begin
            cnt_d   = '0;
            armed_d = (state_d == S_STORE) ? !compelete_store : !compelete_replay;
        end
        if ((state_d == S_ERR) && (state_q != S_ERR)) begin
            error_d = 1'b1;
        end
        if (state_d == S_DONE) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge qdr_clk) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            armed_q       <= 1'b0;
            loops_q       <= '0;
            loop_cnt      <= '0;
            mem_addr_low  <= '0;
            mem_addr_high <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            err_code      <= 2'd0;
            sw_rst        <= 1'b0;
            start_store   <= 1'b0;
            start_replay  <= 1'b0;
            busy          <= 1'b0;
`ifdef DFLOW_SEQ_TIMEOUT_EN
            wd_q          <= '0;
            to_q          <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            armed_q       <= armed_d;
            loops_q       <= loops_d;
            loop_cnt      <= loop_cnt_d;
            mem_addr_low  <= addr_low_d;
            mem_addr_high <= addr_high_d;
            done          <= done_d;
            error         <= error_d;
            err_code      <= err_code_d;
            sw_rst        <= (state_d == S_RST) || (state_d == S_ERR);
            start_store   <= (state_d == S_STORE);
            start_replay  <= (state_d == S_REPLAY);
            busy          <= (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERR);
`ifdef DFLOW_SEQ_TIMEOUT_EN
            wd_q          <= wd_d;
            to_q          <= to_d;
`endif
        end
    end
endmodule
